// File: rtl/circ_pkg.sv
// Shared types and helpers for the circulant transpose buffer: read-mode encoding,
// modular index arithmetic and index-width derivation.
package circ_pkg;

  typedef enum logic {
    RMODE_ROW = 1'b0,
    RMODE_COL = 1'b1
  } rmode_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands are already < n, so one conditional subtract replaces a divider.
  function automatic int unsigned circ_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

  function automatic int unsigned circ_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + n - b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/bram_mem.sv
// Simple dual-port synchronous RAM, read-first on address collision; contents not reset.
module bram_mem import circ_pkg::*; #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/circ_rotator.sv
// Chunk-wise rotator. DIR=0: dout[i] = din[(i+amt) mod N]; DIR=1: dout[i] = din[(i-amt) mod N].
module circ_rotator import circ_pkg::*; #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned AL  = 2,
  parameter bit          DIR = 1'b0
) (
  input  logic [N*W-1:0] din,
  input  logic [AL-1:0]  amt,
  output logic [N*W-1:0] dout
);

  always_comb begin
    int unsigned src;
    src  = 0;
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      src = DIR ? circ_sub(i, 32'(amt), N) : circ_add(i, 32'(amt), N);
      dout[i*W +: W] = din[src*W +: W];
    end
  end

endmodule

// File: rtl/circulant_transpose_buffer.sv
// Multi-tile circulant-placed matrix buffer: row writes, row or transposed-column reads
// at fixed latency, and per-tile completeness tracking for ping-pong use.
module circulant_transpose_buffer import circ_pkg::*; #(
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned NUM_TILES  = 2,
  parameter int unsigned ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
  parameter int unsigned ADDR_LEN   = clog2_min1(MATRIX_DIM),
  parameter int unsigned TILE_W     = clog2_min1(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wen,
  input  logic [TILE_W-1:0]    wtile,
  input  logic [ADDR_LEN-1:0]  waddr,
  input  logic [ROW_WIDTH-1:0] wdata,
  input  logic                 ren,
  input  logic                 rmode,
  input  logic [TILE_W-1:0]    rtile,
  input  logic [ADDR_LEN-1:0]  raddr,
  input  logic [NUM_TILES-1:0] tile_clr,
  output logic                 rvalid,
  output logic [ROW_WIDTH-1:0] rdata,
  output logic [NUM_TILES-1:0] tile_ready
);

  localparam int unsigned N     = MATRIX_DIM;
  localparam int unsigned W     = MEM_WIDTH;
  localparam int unsigned DEPTH = N * NUM_TILES;
  localparam int unsigned AW    = clog2_min1(DEPTH);

  logic                 wen_q,   wen_d;
  logic [TILE_W-1:0]    wtile_q, wtile_d;
  logic [ADDR_LEN-1:0]  waddr_q, waddr_d;
  logic [ROW_WIDTH-1:0] wdata_q, wdata_d;

  logic                 ren_q,   ren_d;
  rmode_e               rmode_q, rmode_d;
  logic [TILE_W-1:0]    rtile_q, rtile_d;
  logic [ADDR_LEN-1:0]  raddr_q, raddr_d;

  logic [AW-1:0]        baddr_q [N];
  logic [AW-1:0]        baddr_d [N];
  logic                 rv1_q, rv1_d, oob1_q, oob1_d;
  logic [ADDR_LEN-1:0]  rot1_q, rot1_d;
  logic                 rv2_q, rv2_d, oob2_q, oob2_d;
  logic [ADDR_LEN-1:0]  rot2_q, rot2_d;

  logic                 rvalid_q, rvalid_d;
  logic [ROW_WIDTH-1:0] rdata_q,  rdata_d;
  logic [N-1:0]         bitmap_q [NUM_TILES];
  logic [N-1:0]         bitmap_d [NUM_TILES];
  logic [NUM_TILES-1:0] tile_ready_q, tile_ready_d;

  logic                 wr_hit;
  logic [AW-1:0]        bank_waddr;
  logic [ROW_WIDTH-1:0] bank_wdata;
  logic [ROW_WIDTH-1:0] bank_rdata;
  logic [ROW_WIDTH-1:0] rd_collect;

  always_comb begin
    int unsigned row;
    row = 0;

    wen_d   = wen;
    wtile_d = wtile;
    waddr_d = waddr;
    wdata_d = wdata;
    ren_d   = ren;
    rmode_d = rmode_e'(rmode);
    rtile_d = rtile;
    raddr_d = raddr;

    wr_hit     = wen_q && (32'(wtile_q) < NUM_TILES) && (32'(waddr_q) < N);
    bank_waddr = AW'(32'(wtile_q) * N + 32'(waddr_q));

    // Column j lives on the anti-diagonal: bank m holds row (m-j) mod N.
    for (int unsigned m = 0; m < N; m++) begin
      row        = (rmode_q == RMODE_COL) ? circ_sub(m, 32'(raddr_q), N) : 32'(raddr_q);
      baddr_d[m] = AW'(32'(rtile_q) * N + row);
    end
    rv1_d  = ren_q;
    oob1_d = ren_q && !(32'(rtile_q) < NUM_TILES);
    rot1_d = raddr_q;

    rv2_d  = rv1_q;
    oob2_d = oob1_q;
    rot2_d = rot1_q;

    rvalid_d = rv2_q;
    rdata_d  = rdata_q;
    if (rv2_q) rdata_d = oob2_q ? '0 : rd_collect;

    // Clear is applied after the commit so it wins on a same-edge collision.
    for (int unsigned t = 0; t < NUM_TILES; t++) begin
      bitmap_d[t] = bitmap_q[t];
      if (wr_hit && (32'(wtile_q) == t)) bitmap_d[t][waddr_q] = 1'b1;
      if (tile_clr[t]) bitmap_d[t] = '0;
      tile_ready_d[t] = &bitmap_d[t];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q        <= 1'b0;
      wtile_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      ren_q        <= 1'b0;
      rmode_q      <= RMODE_ROW;
      rtile_q      <= '0;
      raddr_q      <= '0;
      baddr_q      <= '{default: '0};
      rv1_q        <= 1'b0;
      oob1_q       <= 1'b0;
      rot1_q       <= '0;
      rv2_q        <= 1'b0;
      oob2_q       <= 1'b0;
      rot2_q       <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      bitmap_q     <= '{default: '0};
      tile_ready_q <= '0;
    end else begin
      wen_q        <= wen_d;
      wtile_q      <= wtile_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      ren_q        <= ren_d;
      rmode_q      <= rmode_d;
      rtile_q      <= rtile_d;
      raddr_q      <= raddr_d;
      baddr_q      <= baddr_d;
      rv1_q        <= rv1_d;
      oob1_q       <= oob1_d;
      rot1_q       <= rot1_d;
      rv2_q        <= rv2_d;
      oob2_q       <= oob2_d;
      rot2_q       <= rot2_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      bitmap_q     <= bitmap_d;
      tile_ready_q <= tile_ready_d;
    end
  end

  circ_rotator #(.N(N), .W(W), .AL(ADDR_LEN), .DIR(1'b1)) u_wr_rot (
    .din  (wdata_q),
    .amt  (waddr_q),
    .dout (bank_wdata)
  );

  circ_rotator #(.N(N), .W(W), .AL(ADDR_LEN), .DIR(1'b0)) u_rd_rot (
    .din  (bank_rdata),
    .amt  (rot2_q),
    .dout (rd_collect)
  );

  for (genvar m = 0; m < N; m++) begin : g_bank
    bram_mem #(.DATAW(W), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (wr_hit),
      .waddr (bank_waddr),
      .wdata (bank_wdata[m*W +: W]),
      .re    (rv1_q && !oob1_q),
      .raddr (baddr_q[m]),
      .rdata (bank_rdata[m*W +: W])
    );
  end

  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign tile_ready = tile_ready_q;

endmodule

// File: tb/tb_circulant_transpose_buffer.sv
// Scoreboard bench: a tile-array model predicts read results and tile_ready; a negedge
// monitor pops expectations whenever rvalid is seen.
module tb_circulant_transpose_buffer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic [0:0]    wtile = '0;
  logic [1:0]    waddr = '0;
  logic [31:0]   wdata = '0;
  logic          ren = 1'b0;
  logic          rmode = 1'b0;
  logic [0:0]    rtile = '0;
  logic [1:0]    raddr = '0;
  logic [NT-1:0] tile_clr = '0;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [NT-1:0] tile_ready;

  circulant_transpose_buffer #(.MATRIX_DIM(N), .MEM_WIDTH(W), .NUM_TILES(NT)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wtile(wtile), .waddr(waddr), .wdata(wdata),
    .ren(ren), .rmode(rmode), .rtile(rtile), .raddr(raddr), .tile_clr(tile_clr),
    .rvalid(rvalid), .rdata(rdata), .tile_ready(tile_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [31:0] data; int unsigned due; } exp_t;
  typedef struct { int t; int r; int unsigned due; } commit_t;
  typedef struct { logic [NT-1:0] mask; int unsigned due; } clr_t;

  logic [7:0]   mem   [NT][N][N];
  bit   [N-1:0] mbits [NT];
  exp_t         exps[$];
  commit_t      commits[$];
  clr_t         clrs[$];

  function automatic logic [31:0] model_read(input bit col, input int t, input int a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = col ? mem[t][i][a] : mem[t][a][i];
    return v;
  endfunction

  function automatic logic [31:0] enc_row(input int t, input int r);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*W +: W] = 8'((t << 6) | (r << 3) | c);
    return v;
  endfunction

  task automatic step(input bit we, input int wt, input int wa, input logic [31:0] wd,
                      input bit re, input bit rm, input int rt, input int ra,
                      input logic [NT-1:0] clr);
    @(posedge clk);
    #1;
    wen = we; wtile = 1'(wt); waddr = 2'(wa); wdata = wd;
    ren = re; rmode = rm; rtile = 1'(rt); raddr = 2'(ra); tile_clr = clr;
    if (we) begin
      for (int c = 0; c < N; c++) mem[wt][wa][c] = wd[c*W +: W];
      commits.push_back('{wt, wa, cyc + 2});
    end
    if (clr != '0) clrs.push_back('{clr, cyc + 1});
    if (re) exps.push_back('{model_read(rm, rt, ra), cyc + 4});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (rvalid) chk("rvalid_in_reset", rvalid, 1'b0);
    end else begin
      logic [NT-1:0] exp_ready;
      while (commits.size() > 0 && commits[0].due <= cyc) begin
        commit_t cm;
        cm = commits.pop_front();
        mbits[cm.t][cm.r] = 1'b1;
      end
      while (clrs.size() > 0 && clrs[0].due <= cyc) begin
        clr_t cl;
        cl = clrs.pop_front();
        for (int t = 0; t < NT; t++) if (cl.mask[t]) mbits[t] = '0;
      end
      for (int t = 0; t < NT; t++) exp_ready[t] = &mbits[t];
      chk("tile_ready", tile_ready, exp_ready);
      if (rvalid) begin
        if (exps.size() == 0) chk("rvalid_unexpected", rvalid, 1'b0);
        else begin
          exp_t e;
          e = exps.pop_front();
          chk("rdata", rdata, e.data);
          chk("rvalid_cycle", cyc, e.due);
        end
      end else if (exps.size() > 0 && exps[0].due < cyc) begin
        void'(exps.pop_front());
        chk("rvalid_missing", rvalid, 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nv;
    for (int t = 0; t < NT; t++) mbits[t] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_tile_ready", tile_ready, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < N; r++) step(1, 0, r, enc_row(0, r), 0, 0, 0, 0, '0);
    step(0, 0, 0, '0, 1, 1, 0, 2, '0);
    step(0, 0, 0, '0, 1, 0, 0, 1, '0);
    idle(4);
    chk("tile0_ready", tile_ready, 2'b01);

    for (int j = 0; j < N; j++) step(0, 0, 0, '0, 1, 1, 0, j, '0);
    idle(5);

    for (int r = 0; r < N; r++) step(1, 1, r, enc_row(1, r), 0, 0, 0, 0, '0);
    idle(3);
    nv = $urandom;
    step(1, 1, 3, nv, 1, 1, 1, 0, '0);
    idle(5);
    step(0, 0, 0, '0, 1, 1, 1, 0, '0);
    nv = $urandom;
    step(1, 1, 3, nv, 0, 0, 0, 0, '0);
    idle(5);

    step(1, 0, 0, enc_row(0, 0), 0, 0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, 0, 0, 2'b01);
    idle(3);
    chk("clr_wins_ready", tile_ready, 2'b10);
    for (int r = 1; r < N; r++) step(1, 0, r, enc_row(0, r), 0, 0, 0, 0, '0);
    idle(3);
    chk("partial_rewrite_ready", tile_ready, 2'b10);
    step(1, 0, 0, enc_row(0, 0), 0, 0, 0, 0, '0);
    idle(3);
    chk("rewrite_complete_ready", tile_ready, 2'b11);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, NT - 1), $urandom_range(0, N - 1), $urandom,
           $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, NT - 1),
           $urandom_range(0, N - 1), ($urandom_range(0, 19) == 0) ? NT'($urandom_range(1, 3)) : '0);
    idle(6);

    step(0, 0, 0, '0, 1, 1, 0, 1, '0);
    step(0, 0, 0, '0, 1, 0, 1, 2, '0);
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 1'b0; tile_clr = '0;
    rst_n = 1'b0;
    exps.delete();
    commits.delete();
    clrs.delete();
    for (int t = 0; t < NT; t++) mbits[t] = '0;
    #1;
    chk("midreset_rvalid", rvalid, 1'b0);
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_tile_ready", tile_ready, 2'b00);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int t = 0; t < NT; t++)
      for (int a = 0; a < N; a++) begin
        step(0, 0, 0, '0, 1, 0, t, a, '0);
        step(0, 0, 0, '0, 1, 1, t, a, '0);
      end
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), $urandom_range(0, NT - 1), $urandom_range(0, N - 1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NT - 1),
           $urandom_range(0, N - 1), '0);
    idle(1);

    for (int i = 0; i < 20 && exps.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", exps.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
